// File: rtl/segment_descriptor_loader_pkg.sv
// Shared types and constants for the segment descriptor loader.
// States, fault encodings and the descriptor/selector bit positions live here.
package segment_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ_LOW,
    ST_READ_HIGH,
    ST_COMMIT,
    ST_FAULT
  } load_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE        = 2'd0,
    FAULT_NULL        = 2'd1,
    FAULT_LIMIT       = 2'd2,
    FAULT_NOT_PRESENT = 2'd3
  } fault_type_t;

  localparam int DESCRIPTOR_PRESENT_BIT = 47;
  localparam int SELECTOR_TI_BIT        = 2;

endpackage

// File: rtl/segment_descriptor_loader_if.sv
// Dword read port between the descriptor loader and memory.
// A request is held until ready; ready also means the data is valid.
interface segment_descriptor_loader_if;

  logic        mem_read_request;
  logic [31:0] mem_read_address;
  logic        mem_read_ready;
  logic [31:0] mem_read_data;

  modport master (
    output mem_read_request,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_request,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );

endinterface

// File: rtl/segment_descriptor_loader_table_check.sv
// Combinational selector validation: picks GDT or LDT, then forms the entry address.
// It also raises the null and limit-violation flags.
module descriptor_table_check
  import segment_loader_pkg::*;
(
  input  logic [15:0] selector,
  input  logic [31:0] gdtr_base,
  input  logic [15:0] gdtr_limit,
  input  logic [31:0] ldtr_base,
  input  logic [31:0] ldtr_limit,
  output logic [31:0] entry_address,
  output logic        is_null,
  output logic        limit_violation
);

  logic        table_indicator;
  logic [31:0] entry_offset;
  logic [31:0] table_base;
  logic [31:0] table_limit;

  always_comb begin
    table_indicator = selector[SELECTOR_TI_BIT];
    entry_offset    = {16'b0, selector[15:3], 3'b000};
    table_base      = table_indicator ? ldtr_base  : gdtr_base;
    table_limit     = table_indicator ? ldtr_limit : {16'b0, gdtr_limit};
    entry_address   = table_base + entry_offset;
    is_null         = (selector[15:3] == 13'd0) && !table_indicator;
    // A 33-bit compare keeps offset+7 from wrapping past a 4 GiB LDT limit.
    limit_violation = ({1'b0, entry_offset} + 33'd7) > {1'b0, table_limit};
  end

endmodule

// File: rtl/segment_descriptor_loader.sv
// Selector-load sequencer: validates a selector, fetches its 8-byte descriptor in two
// dword reads, then commits selector and descriptor together or reports a fault.
module segment_descriptor_loader
  import segment_loader_pkg::*;
#(
  parameter bit ALLOW_NULL_SELECTOR = 1'b0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               load_request,
  input  logic [15:0]                        load_selector,
  input  logic [31:0]                        gdtr_base,
  input  logic [15:0]                        gdtr_limit,
  input  logic [31:0]                        ldtr_base,
  input  logic [31:0]                        ldtr_limit,
  segment_descriptor_loader_if.master        mem,
  output logic                               selector_write_enable,
  output logic [15:0]                        selector_write_data,
  output logic                               descriptor_write_enable,
  output logic [63:0]                        descriptor_write_data,
  output logic                               load_busy,
  output logic                               load_done,
  output logic                               load_fault,
  output logic [1:0]                         fault_type,
  output logic [15:0]                        fault_error_code
);

  load_state_t state_q, state_d;
  fault_type_t fault_type_q, fault_type_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] sel_q, sel_d;
  logic [63:0] desc_q, desc_d;
  logic        commit_q, commit_d;
  logic        fault_q, fault_d;
  logic [15:0] err_q, err_d;

  logic [31:0] entry_address;
  logic        is_null;
  logic        limit_violation;

  descriptor_table_check u_table_check (
    .selector        (sel_q),
    .gdtr_base       (gdtr_base),
    .gdtr_limit      (gdtr_limit),
    .ldtr_base       (ldtr_base),
    .ldtr_limit      (ldtr_limit),
    .entry_address   (entry_address),
    .is_null         (is_null),
    .limit_violation (limit_violation)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    desc_d       = desc_q;
    commit_d     = 1'b0;
    fault_d      = 1'b0;
    fault_type_d = FAULT_NONE;
    err_d        = 16'h0000;

    case (state_q)
      ST_IDLE: begin
        if (load_request) begin
          sel_d   = load_selector;
          desc_d  = 64'h0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (is_null && ALLOW_NULL_SELECTOR) begin
          desc_d   = 64'h0;
          commit_d = 1'b1;
          state_d  = ST_COMMIT;
        end else if (is_null || limit_violation) begin
          fault_d      = 1'b1;
          fault_type_d = is_null ? FAULT_NULL : FAULT_LIMIT;
          err_d        = {sel_q[15:2], 2'b00};
          state_d      = ST_FAULT;
        end else begin
          req_d   = 1'b1;
          addr_d  = entry_address;
          state_d = ST_READ_LOW;
        end
      end
      ST_READ_LOW: begin
        if (mem.mem_read_ready) begin
          desc_d[31:0] = mem.mem_read_data;
          addr_d       = addr_q + 32'd4;
          state_d      = ST_READ_HIGH;
        end
      end
      ST_READ_HIGH: begin
        if (mem.mem_read_ready) begin
          req_d         = 1'b0;
          desc_d[63:32] = mem.mem_read_data;
          if (mem.mem_read_data[DESCRIPTOR_PRESENT_BIT-32]) begin
            commit_d = 1'b1;
            state_d  = ST_COMMIT;
          end else begin
            fault_d      = 1'b1;
            fault_type_d = FAULT_NOT_PRESENT;
            err_d        = {sel_q[15:2], 2'b00};
            state_d      = ST_FAULT;
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Reset discards any half-fetched descriptor and drops the read strobe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      addr_q       <= 32'h0;
      sel_q        <= 16'h0;
      desc_q       <= 64'h0;
      commit_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_type_q <= FAULT_NONE;
      err_q        <= 16'h0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      desc_q       <= desc_d;
      commit_q     <= commit_d;
      fault_q      <= fault_d;
      fault_type_q <= fault_type_d;
      err_q        <= err_d;
    end
  end

  assign mem.mem_read_request    = req_q;
  assign mem.mem_read_address    = addr_q;
  assign selector_write_enable   = commit_q;
  assign descriptor_write_enable = commit_q;
  assign load_done               = commit_q;
  assign selector_write_data     = sel_q;
  assign descriptor_write_data   = desc_q;
  assign load_busy               = (state_q != ST_IDLE);
  assign load_fault              = fault_q;
  assign fault_type              = fault_type_q;
  assign fault_error_code        = err_q;

endmodule

// File: tb/tb_segment_descriptor_loader.sv
// Directed bench for segment_descriptor_loader: one instance faults on null selectors,
// the other commits them with an empty descriptor.
module tb_segment_descriptor_loader;

  logic        clock;
  logic        reset;
  logic        load_request;
  logic        load_request_n;
  logic [15:0] load_selector;
  logic [31:0] gdtr_base;
  logic [15:0] gdtr_limit;
  logic [31:0] ldtr_base;
  logic [31:0] ldtr_limit;

  logic        sel_we, desc_we, busy, done, fault;
  logic [15:0] sel_data, err_code;
  logic [63:0] desc_data;
  logic [1:0]  ftype;

  logic        sel_we_n, desc_we_n, busy_n, done_n, fault_n;
  logic [15:0] sel_data_n, err_code_n;
  logic [63:0] desc_data_n;
  logic [1:0]  ftype_n;

  int total = 0;
  int bad   = 0;

  segment_descriptor_loader_if mem_if ();
  segment_descriptor_loader_if mem_if_n ();

  segment_descriptor_loader #(.ALLOW_NULL_SELECTOR(1'b0)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .load_request            (load_request),
    .load_selector           (load_selector),
    .gdtr_base               (gdtr_base),
    .gdtr_limit              (gdtr_limit),
    .ldtr_base               (ldtr_base),
    .ldtr_limit              (ldtr_limit),
    .mem                     (mem_if.master),
    .selector_write_enable   (sel_we),
    .selector_write_data     (sel_data),
    .descriptor_write_enable (desc_we),
    .descriptor_write_data   (desc_data),
    .load_busy               (busy),
    .load_done               (done),
    .load_fault              (fault),
    .fault_type              (ftype),
    .fault_error_code        (err_code)
  );

  segment_descriptor_loader #(.ALLOW_NULL_SELECTOR(1'b1)) dut_null (
    .clock                   (clock),
    .reset                   (reset),
    .load_request            (load_request_n),
    .load_selector           (load_selector),
    .gdtr_base               (gdtr_base),
    .gdtr_limit              (gdtr_limit),
    .ldtr_base               (ldtr_base),
    .ldtr_limit              (ldtr_limit),
    .mem                     (mem_if_n.master),
    .selector_write_enable   (sel_we_n),
    .selector_write_data     (sel_data_n),
    .descriptor_write_enable (desc_we_n),
    .descriptor_write_data   (desc_data_n),
    .load_busy               (busy_n),
    .load_done               (done_n),
    .load_fault              (fault_n),
    .fault_type              (ftype_n),
    .fault_error_code        (err_code_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [15:0] sel);
    load_request  = req;
    load_selector = sel;
  endtask

  task automatic memRespond(input logic ready, input logic [31:0] data);
    mem_if.mem_read_ready = ready;
    mem_if.mem_read_data  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset          = 1'b0;
    load_request   = 1'b0;
    load_request_n = 1'b0;
    load_selector  = 16'h0;
    gdtr_base      = 32'h0000_1000;
    gdtr_limit     = 16'h00FF;
    ldtr_base      = 32'h0000_2000;
    ldtr_limit     = 32'h0000_001F;
    memRespond(1'b0, 32'h0);
    mem_if_n.mem_read_ready = 1'b0;
    mem_if_n.mem_read_data  = 32'h0;

    step();
    step();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_req", mem_if.mem_read_request, 0);
    checkOutput("reset_addr", mem_if.mem_read_address, 0);
    checkOutput("reset_sel_we", sel_we, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_fault", fault, 0);
    checkOutput("reset_ftype", ftype, 0);
    checkOutput("reset_desc", desc_data, 0);
    checkOutput("reset_sel", sel_data, 0);
    checkOutput("reset_err", err_code, 0);
    reset = 1'b1;
    step();

    $display("[TB] GDT load, zero-wait");
    applyStimulus(1'b1, 16'h0010);
    step();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("gdt_c1_busy", busy, 1);
    checkOutput("gdt_c1_req", mem_if.mem_read_request, 0);
    step();
    checkOutput("gdt_c2_req", mem_if.mem_read_request, 1);
    checkOutput("gdt_c2_addr", mem_if.mem_read_address, 32'h0000_1010);
    memRespond(1'b1, 32'h0000_FFFF);
    step();
    checkOutput("gdt_c3_req", mem_if.mem_read_request, 1);
    checkOutput("gdt_c3_addr", mem_if.mem_read_address, 32'h0000_1014);
    checkOutput("gdt_c3_we", sel_we, 0);
    memRespond(1'b1, 32'h00CF_9300);
    step();
    memRespond(1'b0, 32'h0);
    checkOutput("gdt_c4_sel_we", sel_we, 1);
    checkOutput("gdt_c4_desc_we", desc_we, 1);
    checkOutput("gdt_c4_done", done, 1);
    checkOutput("gdt_c4_desc", desc_data, 64'h00CF_9300_0000_FFFF);
    checkOutput("gdt_c4_sel", sel_data, 16'h0010);
    checkOutput("gdt_c4_req", mem_if.mem_read_request, 0);
    step();
    checkOutput("gdt_c5_done", done, 0);
    checkOutput("gdt_c5_sel_we", sel_we, 0);
    checkOutput("gdt_c5_busy", busy, 0);

    $display("[TB] LDT limit fault");
    applyStimulus(1'b1, 16'h0024);
    step();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("ldt_c1_fault", fault, 0);
    step();
    checkOutput("ldt_c2_fault", fault, 1);
    checkOutput("ldt_c2_ftype", ftype, 2);
    checkOutput("ldt_c2_err", err_code, 16'h0024);
    checkOutput("ldt_c2_req", mem_if.mem_read_request, 0);
    checkOutput("ldt_c2_we", sel_we, 0);
    step();
    checkOutput("ldt_c3_fault", fault, 0);
    checkOutput("ldt_c3_busy", busy, 0);

    $display("[TB] null selector");
    applyStimulus(1'b1, 16'h0000);
    load_request_n = 1'b1;
    step();
    applyStimulus(1'b0, 16'h0000);
    load_request_n = 1'b0;
    checkOutput("null_c1_req_n", mem_if_n.mem_read_request, 0);
    step();
    checkOutput("null_c2_fault", fault, 1);
    checkOutput("null_c2_ftype", ftype, 1);
    checkOutput("null_c2_err", err_code, 16'h0000);
    checkOutput("null_c2_we", desc_we, 0);
    checkOutput("null_c2_sel_we_n", sel_we_n, 1);
    checkOutput("null_c2_desc_we_n", desc_we_n, 1);
    checkOutput("null_c2_done_n", done_n, 1);
    checkOutput("null_c2_desc_n", desc_data_n, 64'h0);
    checkOutput("null_c2_sel_n", sel_data_n, 16'h0000);
    checkOutput("null_c2_fault_n", fault_n, 0);
    checkOutput("null_c2_ftype_n", ftype_n, 0);
    checkOutput("null_c2_err_n", err_code_n, 0);
    checkOutput("null_c2_req_n", mem_if_n.mem_read_request, 0);
    step();
    checkOutput("null_c3_done_n", done_n, 0);
    checkOutput("null_c3_busy_n", busy_n, 0);

    $display("[TB] not present with wait states");
    applyStimulus(1'b1, 16'h0018);
    step();
    applyStimulus(1'b0, 16'h0000);
    step();
    for (int i = 0; i < 3; i++) begin
      checkOutput("np_low_wait_req", mem_if.mem_read_request, 1);
      checkOutput("np_low_wait_addr", mem_if.mem_read_address, 32'h0000_1018);
      step();
    end
    memRespond(1'b1, 32'h1234_5678);
    checkOutput("np_low_addr", mem_if.mem_read_address, 32'h0000_1018);
    step();
    memRespond(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("np_high_wait_req", mem_if.mem_read_request, 1);
      checkOutput("np_high_wait_addr", mem_if.mem_read_address, 32'h0000_101C);
      checkOutput("np_high_wait_we", sel_we, 0);
      step();
    end
    memRespond(1'b1, 32'h00CF_1300);
    step();
    memRespond(1'b0, 32'h0);
    checkOutput("np_fault", fault, 1);
    checkOutput("np_ftype", ftype, 3);
    checkOutput("np_err", err_code, 16'h0018);
    checkOutput("np_sel_we", sel_we, 0);
    checkOutput("np_desc_we", desc_we, 0);
    checkOutput("np_done", done, 0);
    checkOutput("np_req", mem_if.mem_read_request, 0);

    $display("[TB] address wrap and busy");
    step();
    gdtr_base = 32'hFFFF_FFF8;
    applyStimulus(1'b1, 16'h0008);
    step();
    applyStimulus(1'b0, 16'h0000);
    step();
    checkOutput("wrap_c2_addr", mem_if.mem_read_address, 32'h0000_0000);
    checkOutput("wrap_c2_busy", busy, 1);
    applyStimulus(1'b1, 16'h0010);
    step();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("wrap_c3_addr", mem_if.mem_read_address, 32'h0000_0000);
    checkOutput("wrap_c3_busy", busy, 1);
    checkOutput("wrap_c3_sel", sel_data, 16'h0008);
    memRespond(1'b1, 32'h0000_FFFF);
    step();
    checkOutput("wrap_c4_addr", mem_if.mem_read_address, 32'h0000_0004);
    memRespond(1'b1, 32'h00CF_9300);
    step();
    memRespond(1'b0, 32'h0);
    checkOutput("wrap_done", done, 1);
    checkOutput("wrap_sel", sel_data, 16'h0008);
    checkOutput("wrap_desc", desc_data, 64'h00CF_9300_0000_FFFF);
    step();
    checkOutput("wrap_idle_busy", busy, 0);

    $display("[TB] mid-load reset");
    gdtr_base = 32'h0000_1000;
    applyStimulus(1'b1, 16'h0010);
    step();
    applyStimulus(1'b0, 16'h0000);
    step();
    memRespond(1'b1, 32'hAAAA_5555);
    step();
    memRespond(1'b0, 32'h0);
    checkOutput("mid_c3_req", mem_if.mem_read_request, 1);
    checkOutput("mid_c3_addr", mem_if.mem_read_address, 32'h0000_1014);
    reset = 1'b0;
    step();
    reset = 1'b1;
    checkOutput("mid_req", mem_if.mem_read_request, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_desc", desc_data, 64'h0);
    checkOutput("mid_sel_we", sel_we, 0);
    memRespond(1'b1, 32'h00CF_9300);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("mid_after_done", done, 0);
      checkOutput("mid_after_we", sel_we, 0);
      checkOutput("mid_after_busy", busy, 0);
    end
    memRespond(1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
